axil_mem_mmio: RTL and testbench
================================

AXIL_MEM_MMIO -- requirements
Module: axil_mem_mmio

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 524288, meaning the number of 32-bit RAM words at byte address 0 (2 MiB).
REQ-002 SHALL have parameter NUM_REGS, default 4 (range 1..64), meaning the number of control registers and status words.
REQ-003 SHALL have parameter RD_LATENCY, default 0 (range 0..15), meaning the wait cycles between AR handshake and rvalid.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 mem_axi_awvalid  in  1  write-address valid.
REQ-007 mem_axi_awready  out  1  write-address ready.
REQ-008 mem_axi_awaddr  in  32  write byte address.
REQ-009 mem_axi_wvalid  in  1  write-data valid.
REQ-010 mem_axi_wready  out  1  write-data ready.
REQ-011 mem_axi_wdata  in  32  write data.
REQ-012 mem_axi_wstrb  in  4  byte strobes.
REQ-013 mem_axi_bvalid  out  1  write-response valid.
REQ-014 mem_axi_bready  in  1  write-response ready.
REQ-015 mem_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR).
REQ-016 mem_axi_arvalid  in  1  read-address valid.
REQ-017 mem_axi_arready  out  1  read-address ready.
REQ-018 mem_axi_araddr  in  32  read byte address.
REQ-019 mem_axi_rvalid  out  1  read-data valid.
REQ-020 mem_axi_rready  in  1  read-data ready.
REQ-021 mem_axi_rdata  out  32  read data.
REQ-022 mem_axi_rresp  out  2  read response (00 OKAY, 10 SLVERR).
REQ-023 cons_valid  out  1  one-cycle pulse when a console byte is written.
REQ-024 cons_data  out  8  console byte, valid with cons_valid.
REQ-025 tests_passed  out  1  sticky pass flag.
REQ-026 ctrl_regs  out  32*NUM_REGS  control registers, register i at bits [32i+31:32i].
REQ-027 stat_in  in  32*NUM_REGS  status words from the accelerator, same packing.

Function
REQ-028 Address map SHALL be: RAM at addr < 4*MEM_WORDS (RW); console 0x1000_0000 (WO, byte = wdata[7:0]); pass 0x2000_0000 and 0x2100_0000 (WO, wdata==1 sets tests_passed); ctrl 0x3000_0000+4i (RW); stat 0x3000_0100+4i (RO); everything else unmapped.
REQ-029 Write FSM SHALL use states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP; AW and W are accepted independently, in either order or in the same cycle; awready/wready are high only in states that can still accept that channel.
REQ-030 Write SHALL commit on the cycle W_RESP is entered, honouring wstrb per byte for RAM and ctrl; bvalid then rises the next cycle and holds until bready, then returns to W_IDLE.
REQ-031 Read FSM SHALL use states R_IDLE, R_WAIT, R_RESP; arready high only in R_IDLE; R_WAIT lasts exactly RD_LATENCY cycles (skipped when 0); data is sampled on entry to R_RESP; rvalid and rdata hold until rready.
REQ-032 Minimum latency: AR handshake at cycle N -> rvalid at N+1+RD_LATENCY; AW+W handshake at cycle N -> bvalid at N+1.
REQ-033 Console and pass writes SHALL have no effect on RAM; console reads return 0; cons_valid pulses exactly once per committed console write.
REQ-034 Writes to stat addresses and to unmapped addresses SHALL be dropped without side effects.
REQ-035 Read and write channels run concurrently; same-word collision: a read sampled in the commit cycle returns the pre-write value.
REQ-036 tests_passed SHALL remain 1 until reset; a write of any value other than 1 to a pass address leaves it unchanged.

Reset
REQ-037 While reset is high, all outputs SHALL be 0, both FSMs idle, ctrl_regs 0, latency counter 0; RAM contents are not cleared.
REQ-038 Reset asserted mid-transaction SHALL abandon the transaction; a write not yet committed SHALL leave no trace.

Configuration
REQ-039 With AXIL_MMIO_ERR_RESP_EN defined, unmapped or stat-write accesses SHALL return bresp/rresp = 10 (SLVERR) with rdata 0; undefined, they SHALL return 00 (OKAY) with rdata 0.

Verification
REQ-040 Write 0xDEADBEEF to 0x100 with wstrb=0101, then read 0x100 -> rdata 0x00AD00EF, rresp 00.
REQ-041 W presented 3 cycles before AW to 0x3000_0004 with data 5 -> a single bvalid; ctrl_regs[63:32]=5.
REQ-042 RD_LATENCY=3, AR at cycle 10 -> rvalid first high at cycle 14; rready low for 2 cycles -> rdata stable.
REQ-043 Write 0x41 to 0x1000_0000, then 1 to 0x2100_0000 -> one cons_valid pulse with cons_data 0x41; tests_passed=1 until reset.
REQ-044 Read 0x5000_0000 -> rdata 0, rresp 10 with AXIL_MMIO_ERR_RESP_EN, 00 without; subsequent RAM access unaffected.

Source files
------------

// File: rtl/axil_mem_mmio.sv
// AXI4-Lite slave: word RAM at 0, console/pass mailboxes, control and status registers.
// Define AXIL_MMIO_ERR_RESP_EN to answer unmapped and status-write accesses with SLVERR.
module axil_mem_mmio #(
  parameter int MEM_WORDS  = 524288,
  parameter int NUM_REGS   = 4,
  parameter int RD_LATENCY = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_axi_awvalid,
  output logic                     mem_axi_awready,
  input  logic [31:0]              mem_axi_awaddr,
  input  logic                     mem_axi_wvalid,
  output logic                     mem_axi_wready,
  input  logic [31:0]              mem_axi_wdata,
  input  logic [3:0]               mem_axi_wstrb,
  output logic                     mem_axi_bvalid,
  input  logic                     mem_axi_bready,
  output logic [1:0]               mem_axi_bresp,
  input  logic                     mem_axi_arvalid,
  output logic                     mem_axi_arready,
  input  logic [31:0]              mem_axi_araddr,
  output logic                     mem_axi_rvalid,
  input  logic                     mem_axi_rready,
  output logic [31:0]              mem_axi_rdata,
  output logic [1:0]               mem_axi_rresp,
  output logic                     cons_valid,
  output logic [7:0]               cons_data,
  output logic                     tests_passed,
  output logic [32*NUM_REGS-1:0]   ctrl_regs,
  input  logic [32*NUM_REGS-1:0]   stat_in
);
  // state    | meaning
  // W_IDLE   | no write in flight, AW and W both accepted
  // W_HAVE_A | address held, waiting for data
  // W_HAVE_D | data held, waiting for address
  // W_RESP   | write committed, bvalid until bready
  // R_IDLE   | waiting for AR
  // R_WAIT   | RD_LATENCY wait cycles before sampling
  // R_RESP   | rdata captured, rvalid until rready

  localparam int MAW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int RAW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;
  localparam logic [3:0]  LAT_LOAD  = (RD_LATENCY == 0) ? 4'd0 : 4'(RD_LATENCY - 1);
`ifdef AXIL_MMIO_ERR_RESP_EN
  localparam logic [1:0] RESP_ERR = 2'b10;
`else
  localparam logic [1:0] RESP_ERR = 2'b00;
`endif

  typedef enum logic [2:0] {RG_RAM, RG_CONS, RG_PASS, RG_CTRL, RG_STAT, RG_NONE} region_e;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

  function automatic region_e decode(input logic [31:0] a);
    logic in_regs;
    in_regs = ({1'b0, a[7:2]} < 7'(NUM_REGS));
    if ({1'b0, a} < RAM_BYTES)                              return RG_RAM;
    else if (a[31:2] == 30'h0400_0000)                      return RG_CONS;
    else if (a[31:2] == 30'h0800_0000 || a[31:2] == 30'h0840_0000) return RG_PASS;
    else if (a[31:8] == 24'h30_0000 && in_regs)             return RG_CTRL;
    else if (a[31:8] == 24'h30_0001 && in_regs)             return RG_STAT;
    else                                                    return RG_NONE;
  endfunction

  logic [31:0] mem [MEM_WORDS];
  logic [NUM_REGS-1:0][31:0] ctrl_q;

  // ---------------- write channel ----------------
  w_state_e    w_state, w_next;
  logic [31:0] awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wa, wd;
  logic [3:0]  ws;
  logic        aw_hs, w_hs, commit;
  region_e     w_reg;
  logic [MAW-1:0] w_word;
  logic [RAW-1:0] w_ridx;

  assign mem_axi_awready = !reset && (w_state == W_IDLE || w_state == W_HAVE_D);
  assign mem_axi_wready  = !reset && (w_state == W_IDLE || w_state == W_HAVE_A);
  assign mem_axi_bvalid  = (w_state == W_RESP);
  assign aw_hs = mem_axi_awvalid && mem_axi_awready;
  assign w_hs  = mem_axi_wvalid && mem_axi_wready;

  // Whichever half arrives last comes straight off the bus, the other from its holding register.
  assign wa = (w_state == W_HAVE_A) ? awaddr_q : mem_axi_awaddr;
  assign wd = (w_state == W_HAVE_D) ? wdata_q  : mem_axi_wdata;
  assign ws = (w_state == W_HAVE_D) ? wstrb_q  : mem_axi_wstrb;
  assign w_reg  = decode(wa);
  assign w_word = wa[2 +: MAW];
  assign w_ridx = wa[2 +: RAW];

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_RESP;
        else if (aw_hs)    w_next = W_HAVE_A;
        else if (w_hs)     w_next = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)           w_next = W_RESP;
      W_HAVE_D: if (aw_hs)          w_next = W_RESP;
      W_RESP:   if (mem_axi_bready) w_next = W_IDLE;
      default:                      w_next = W_IDLE;
    endcase
  end

  assign commit = (w_state != W_RESP) && (w_next == W_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state       <= W_IDLE;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      mem_axi_bresp <= 2'b00;
      cons_valid    <= 1'b0;
      cons_data     <= 8'h00;
      tests_passed  <= 1'b0;
      ctrl_q        <= '0;
    end else begin
      w_state    <= w_next;
      cons_valid <= 1'b0;
      if (aw_hs) awaddr_q <= mem_axi_awaddr;
      if (w_hs) begin
        wdata_q <= mem_axi_wdata;
        wstrb_q <= mem_axi_wstrb;
      end
      if (commit) begin
        mem_axi_bresp <= (w_reg == RG_NONE || w_reg == RG_STAT) ? RESP_ERR : 2'b00;
        case (w_reg)
          RG_CONS: begin
            cons_valid <= 1'b1;
            cons_data  <= wd[7:0];
          end
          RG_PASS: if (wd == 32'd1) tests_passed <= 1'b1;
          RG_CTRL: begin
            for (int b = 0; b < 4; b++)
              if (ws[b]) ctrl_q[w_ridx][8*b +: 8] <= wd[8*b +: 8];
          end
          default: ;
        endcase
      end
    end
  end

  // RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit && w_reg == RG_RAM)
      for (int b = 0; b < 4; b++)
        if (ws[b]) mem[w_word][8*b +: 8] <= wd[8*b +: 8];
  end

  assign ctrl_regs = ctrl_q;

  // ---------------- read channel ----------------
  r_state_e    r_state, r_next;
  logic [31:0] araddr_q, ra;
  logic [3:0]  lat_cnt;
  logic        ar_hs, r_load;
  region_e     r_reg;
  logic [MAW-1:0] r_word;
  logic [RAW-1:0] r_ridx;
  logic        rd_sel_ram;
  logic [31:0] ram_rd_q, rd_reg_q;

  assign mem_axi_arready = !reset && (r_state == R_IDLE);
  assign mem_axi_rvalid  = (r_state == R_RESP);
  assign ar_hs  = mem_axi_arvalid && mem_axi_arready;
  assign ra     = (r_state == R_IDLE) ? mem_axi_araddr : araddr_q;
  assign r_reg  = decode(ra);
  assign r_word = ra[2 +: MAW];
  assign r_ridx = ra[2 +: RAW];

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = (RD_LATENCY == 0) ? R_RESP : R_WAIT;
      R_WAIT:  if (lat_cnt == 4'd0) r_next = R_RESP;
      R_RESP:  if (mem_axi_rready)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  assign r_load = (r_state != R_RESP) && (r_next == R_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= R_IDLE;
      araddr_q      <= '0;
      lat_cnt       <= 4'd0;
      mem_axi_rresp <= 2'b00;
      rd_sel_ram    <= 1'b0;
      rd_reg_q      <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        araddr_q <= mem_axi_araddr;
        lat_cnt  <= LAT_LOAD;
      end else if (r_state == R_WAIT && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (r_load) begin
        rd_sel_ram    <= (r_reg == RG_RAM);
        mem_axi_rresp <= (r_reg == RG_NONE) ? RESP_ERR : 2'b00;
        case (r_reg)
          RG_CTRL: rd_reg_q <= ctrl_q[r_ridx];
          RG_STAT: rd_reg_q <= stat_in[{r_ridx, 5'b0} +: 32];
          default: rd_reg_q <= '0;
        endcase
      end
    end
  end

  // Sampling in the commit cycle sees the pre-write word (old value on the same edge).
  always_ff @(posedge clk) begin
    if (r_load && r_reg == RG_RAM) ram_rd_q <= mem[r_word];
  end

  assign mem_axi_rdata = rd_sel_ram ? ram_rd_q : rd_reg_q;

endmodule

// File: tb/tb_axil_mem_mmio.sv
// Directed bench for axil_mem_mmio (MEM_WORDS=1024, NUM_REGS=4, RD_LATENCY=3).
module tb_axil_mem_mmio;
  localparam int RD_LAT = 3;
`ifdef AXIL_MMIO_ERR_RESP_EN
  localparam logic [31:0] ERR = 32'd2;
`else
  localparam logic [31:0] ERR = 32'd0;
`endif

  logic clk, reset;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        cons_valid, tests_passed;
  logic [7:0]  cons_data;
  logic [127:0] ctrl_regs, stat_in;

  int n_tests = 0, n_fail = 0;
  int cons_cnt = 0, b_cnt = 0;
  logic [7:0] cons_last = 8'h00;

  axil_mem_mmio #(.MEM_WORDS(1024), .NUM_REGS(4), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata), .mem_axi_rresp(rresp),
    .cons_valid(cons_valid), .cons_data(cons_data), .tests_passed(tests_passed),
    .ctrl_regs(ctrl_regs), .stat_in(stat_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (cons_valid === 1'b1) begin
      cons_cnt++;
      cons_last = cons_data;
    end
    if (bvalid === 1'b1 && bready === 1'b1) b_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] exp_resp);
    logic aw_done, w_done, aw_h, w_h;
    int k;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; k = 0;
    while (!(aw_done && w_done) && k < 50) begin
      aw_h = awvalid && awready;
      w_h  = wvalid && wready;
      tick(); k++;
      if (aw_h) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_h)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      chk({tag, "_hs_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_bvalid_lat"}, 32'(bvalid), 32'd1);
    chk({tag, "_bresp"}, 32'(bresp), exp_resp);
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                          input logic [31:0] exp_resp, input int stall);
    logic done, h;
    int k, lat;
    araddr = a; arvalid = 1'b1; done = 1'b0; k = 0;
    while (!done && k < 50) begin
      h = arvalid && arready;
      tick(); k++;
      if (h) begin arvalid = 1'b0; done = 1'b1; end
    end
    arvalid = 1'b0;
    if (!done) begin
      chk({tag, "_ar_timeout"}, 32'd0, 32'd1);
      return;
    end
    lat = 1;
    while (!rvalid && lat < 50) begin
      tick(); lat++;
    end
    chk({tag, "_rvalid_lat"}, 32'(lat), 32'(1 + RD_LAT));
    chk({tag, "_rdata"}, rdata, exp_d);
    chk({tag, "_rresp"}, 32'(rresp), exp_resp);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_hold_rvalid"}, 32'(rvalid), 32'd1);
      chk({tag, "_hold_rdata"}, rdata, exp_d);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk({tag, "_rvalid_drop"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    reset = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    stat_in = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    repeat (3) tick();

    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_passed", 32'(tests_passed), 32'd0);
    chk("rst_ctrl", ctrl_regs[31:0] | ctrl_regs[127:96], 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_awready", 32'(awready), 32'd1);
    chk("idle_arready", 32'(arready), 32'd1);

    // strobed RAM write
    axi_write("ram_clr", 32'h100, 32'h0, 4'hF, 32'd0);
    axi_write("ram_strb", 32'h100, 32'hDEADBEEF, 4'b0101, 32'd0);
    axi_read("ram_strb_rd", 32'h100, 32'h00AD00EF, 32'd0, 2);
    axi_write("ram_w0", 32'h0, 32'h12345678, 4'hF, 32'd0);
    axi_write("ram_last", 32'hFFC, 32'hA5A5_0FF0, 4'hF, 32'd0);
    axi_read("ram_last_rd", 32'hFFC, 32'hA5A5_0FF0, 32'd0, 0);

    // W leads AW by three cycles
    b0 = b_cnt;
    wdata = 32'd5; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("wfirst_wready", 32'(wready), 32'd0);
    chk("wfirst_awready", 32'(awready), 32'd1);
    tick(); tick();
    awaddr = 32'h3000_0004; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("wfirst_bvalid", 32'(bvalid), 32'd1);
    tick();
    chk("wfirst_bhold", 32'(bvalid), 32'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    repeat (3) tick();
    chk("wfirst_bcount", 32'(b_cnt - b0), 32'd1);
    chk("wfirst_ctrl1", ctrl_regs[63:32], 32'd5);
    axi_read("ctrl1_rd", 32'h3000_0004, 32'd5, 32'd0, 0);

    axi_write("ctrl0_strb", 32'h3000_0000, 32'hAABBCCDD, 4'b0010, 32'd0);
    chk("ctrl0_val", ctrl_regs[31:0], 32'h0000CC00);

    // console and pass
    axi_write("cons", 32'h1000_0000, 32'h0000_0041, 4'hF, 32'd0);
    chk("cons_count", 32'(cons_cnt), 32'd1);
    chk("cons_data", 32'(cons_last), 32'h41);
    axi_read("cons_rd", 32'h1000_0000, 32'd0, 32'd0, 0);
    axi_read("ram_w0_after_cons", 32'h0, 32'h12345678, 32'd0, 0);
    axi_write("pass_two", 32'h2000_0000, 32'd2, 4'hF, 32'd0);
    chk("pass_not_set", 32'(tests_passed), 32'd0);
    axi_write("pass_one", 32'h2100_0000, 32'd1, 4'hF, 32'd0);
    chk("pass_set", 32'(tests_passed), 32'd1);
    axi_write("pass_zero", 32'h2000_0000, 32'd0, 4'hF, 32'd0);
    chk("pass_sticky", 32'(tests_passed), 32'd1);
    chk("cons_count_end", 32'(cons_cnt), 32'd1);

    // unmapped, status and boundaries
    axi_read("unmapped_rd", 32'h5000_0000, 32'd0, ERR, 0);
    axi_read("ram_after_unmapped", 32'h100, 32'h00AD00EF, 32'd0, 0);
    axi_read("ram_end_rd", 32'h1000, 32'd0, ERR, 0);
    axi_write("ram_end_wr", 32'h1000, 32'hFFFF_FFFF, 4'hF, ERR);
    axi_read("ram_last_intact", 32'hFFC, 32'hA5A5_0FF0, 32'd0, 0);
    axi_write("stat_wr", 32'h3000_0104, 32'h1234_5678, 4'hF, ERR);
    axi_read("stat_rd", 32'h3000_0104, 32'hCAFE0001, 32'd0, 0);
    axi_read("ctrl_oob_rd", 32'h3000_0010, 32'd0, ERR, 0);

    // read sampled in the commit cycle sees the old word
    axi_write("coll_pre", 32'h200, 32'h1111_1111, 4'hF, 32'd0);
    araddr = 32'h200; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick(); tick();
    awaddr = 32'h200; wdata = 32'h2222_2222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("coll_rvalid", 32'(rvalid), 32'd1);
    chk("coll_bvalid", 32'(bvalid), 32'd1);
    chk("coll_old_data", rdata, 32'h1111_1111);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    axi_read("coll_new", 32'h200, 32'h2222_2222, 32'd0, 0);

    // reset with only AW accepted
    awaddr = 32'h100; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_wready", 32'(wready), 32'd0);
    chk("midrst_ctrl1", ctrl_regs[63:32], 32'd0);
    chk("midrst_passed", 32'(tests_passed), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    axi_write("post_rst_wr", 32'h104, 32'h0BAD_F00D, 4'hF, 32'd0);
    axi_read("post_rst_ram", 32'h100, 32'h00AD00EF, 32'd0, 0);
    axi_read("post_rst_ram2", 32'h104, 32'h0BAD_F00D, 32'd0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
